// File: rtl/ds_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ds_fifo
//  Purpose  : Byte FIFO for one Direct Sound channel. Accepts 16/32-bit bus
//             writes (little-endian, low byte first). Pops one signed 8-bit
//             sample per timer overflow. Pulses a DMA sound request when a
//             pop leaves the occupancy at or below REQ_LEVEL.
//  Ports    : clock       core clock
//             reset_n     asynchronous active-low reset
//             fifo_clear  synchronous clear; overrides pop and write
//             wr_en       write strobe (one cycle per bus write)
//             wr_word     1 = 4-byte write, 0 = 2-byte write
//             wr_data     write data, byte [7:0] enqueued first
//             timer_tick  pop strobe
//             sample_out  current sample (registered)
//             count       occupancy in bytes, 0..DEPTH
//             sound_req   one-cycle DMA request pulse
//             overflow    sticky, bytes dropped on write
//             underflow   sticky, pop while empty
//  Macro    : DS_FIFO_UNDERFLOW_ZERO_EN - a pop while empty outputs silence
//             (0) instead of holding the last sample.
//  Revision : 1.0 - initial release
// ============================================================================
module ds_fifo #(
  parameter int DEPTH     = 32,
  parameter int REQ_LEVEL = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       fifo_clear,
  input  logic                       wr_en,
  input  logic                       wr_word,
  input  logic [31:0]                wr_data,
  input  logic                       timer_tick,
  output logic [7:0]                 sample_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       sound_req,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] C_DEPTH     = CW'(DEPTH);
  localparam logic [CW-1:0] C_REQ_LEVEL = CW'(REQ_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } req_state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    sample_q, sample_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  req_state_t    state_q, state_d;

  logic          pop_ok;
  logic [CW-1:0] cnt_pop;     // occupancy after the pop, before the write
  logic [CW-1:0] space;
  logic [2:0]    n_req;
  logic [2:0]    n_acc;
  logic [3:0]    byte_we;
  logic [AW-1:0] byte_addr [4];

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    sample_d    = sample_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    state_d     = state_q;
    pop_ok      = 1'b0;
    cnt_pop     = count_q;
    n_req       = wr_word ? 3'd4 : 3'd2;
    n_acc       = 3'd0;
    byte_we     = 4'b0000;

    // Pop first so a coincident write can use the slot it frees.
    if (timer_tick) begin
      if (count_q != '0) begin
        pop_ok   = 1'b1;
        sample_d = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + AW'(1);
        cnt_pop  = count_q - CW'(1);
      end else begin
        underflow_d = 1'b1;
`ifdef DS_FIFO_UNDERFLOW_ZERO_EN
        sample_d = 8'h00;
`endif
      end
    end

    space = C_DEPTH - cnt_pop;

    // Partial acceptance: as many leading bytes as fit, the rest dropped.
    if (wr_en) begin
      n_acc    = (space >= CW'(n_req)) ? n_req : space[2:0];
      wr_ptr_d = wr_ptr_q + AW'(n_acc);
      if (n_acc != n_req) begin
        overflow_d = 1'b1;
      end
    end

    for (int i = 0; i < 4; i++) begin
      byte_we[i]   = wr_en && (3'(i) < n_acc);
      byte_addr[i] = wr_ptr_q + AW'(i);
    end

    count_d = cnt_pop + CW'(n_acc);

    // Only a real pop can request; writes never do.
    case (state_q)
      ST_IDLE: if (pop_ok && (count_d <= C_REQ_LEVEL)) state_d = ST_REQ;
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: if (count_q > C_REQ_LEVEL) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (fifo_clear) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      sample_d    = 8'h00;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      state_d     = ST_IDLE;
      byte_we     = 4'b0000;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      sample_q    <= 8'h00;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      sample_q    <= sample_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      state_q     <= state_d;
    end
  end

  // Storage needs no reset: contents are only reachable through the pointers.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (byte_we[i]) begin
        mem_q[byte_addr[i]] <= wr_data[8*i +: 8];
      end
    end
  end

  assign sample_out = sample_q;
  assign count      = count_q;
  assign sound_req  = (state_q == ST_REQ);
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ds_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ds_fifo
//  Purpose  : Directed self-checking bench for ds_fifo (DEPTH 32, REQ 16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ds_fifo;

  logic        clock;
  logic        reset_n;
  logic        fifo_clear;
  logic        wr_en;
  logic        wr_word;
  logic [31:0] wr_data;
  logic        timer_tick;
  logic [7:0]  sample_out;
  logic [5:0]  count;
  logic        sound_req;
  logic        overflow;
  logic        underflow;

  int n_checks = 0;
  int n_errors = 0;

  ds_fifo #(.DEPTH(32), .REQ_LEVEL(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .fifo_clear (fifo_clear),
    .wr_en      (wr_en),
    .wr_word    (wr_word),
    .wr_data    (wr_data),
    .timer_tick (timer_tick),
    .sample_out (sample_out),
    .count      (count),
    .sound_req  (sound_req),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs applied at the falling edge, outputs settled 1ns after
  // the rising edge that sampled them.
  task automatic drive(input logic we, input logic ww, input logic [31:0] d,
                       input logic tk, input logic clr);
    @(negedge clock);
    wr_en      = we;
    wr_word    = ww;
    wr_data    = d;
    timer_tick = tk;
    fifo_clear = clr;
    @(posedge clock);
    #1;
    wr_en      = 1'b0;
    wr_word    = 1'b0;
    wr_data    = 32'h0;
    timer_tick = 1'b0;
    fifo_clear = 1'b0;
  endtask

  function automatic logic [31:0] seq_word(input int k);
    logic [7:0] b;
    b = 8'(4 * k);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic fill_words(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b1, seq_word(k), 1'b0, 1'b0);
  endtask

  task automatic tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  logic [7:0] exp_uf_sample;

  initial begin
    reset_n    = 1'b0;
    fifo_clear = 1'b0;
    wr_en      = 1'b0;
    wr_word    = 1'b0;
    wr_data    = 32'h0;
    timer_tick = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_eq("rst_sample", sample_out, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_req", sound_req, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_udf", underflow, 0);

    // Fill with 0x00..0x1F, then drain in order; one request at 17->16.
    fill_words(8);
    check_eq("fill_count", count, 32);
    check_eq("fill_ovf", overflow, 0);
    for (int i = 0; i < 32; i++) begin
      tick();
      check_eq($sformatf("drain_sample%0d", i), sample_out, i);
      check_eq($sformatf("drain_count%0d", i), count, 31 - i);
      check_eq($sformatf("drain_req%0d", i), sound_req, (i == 15) ? 1 : 0);
    end
    check_eq("drain_udf", underflow, 0);

    // Pop while empty.
`ifdef DS_FIFO_UNDERFLOW_ZERO_EN
    exp_uf_sample = 8'h00;
`else
    exp_uf_sample = 8'h1F;
`endif
    tick();
    check_eq("empty_udf", underflow, 1);
    check_eq("empty_count", count, 0);
    check_eq("empty_sample", sample_out, exp_uf_sample);

    // Overflow on full FIFO with a 16-bit write.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("clr_udf", underflow, 0);
    check_eq("clr_sample", sample_out, 0);
    fill_words(8);
    drive(1'b1, 1'b0, 32'h0000BEEF, 1'b0, 1'b0);
    check_eq("full16_count", count, 32);
    check_eq("full16_ovf", overflow, 1);

    // Partial acceptance: count 31, 32-bit write keeps only 0x11.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("clr2_ovf", overflow, 0);
    fill_words(8);
    tick();
    check_eq("part_pre_sample", sample_out, 8'h00);
    check_eq("part_pre_count", count, 31);
    drive(1'b1, 1'b1, 32'h44332211, 1'b0, 1'b0);
    check_eq("part_count", count, 32);
    check_eq("part_ovf", overflow, 1);
    for (int i = 0; i < 32; i++) begin
      tick();
      check_eq($sformatf("part_sample%0d", i), sample_out, (i == 31) ? 32'h11 : i + 1);
    end
    check_eq("part_end_count", count, 0);
    check_eq("part_end_udf", underflow, 0);

    // Coincident pop and write, then request hysteresis.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    fill_words(5);
    tick(); tick(); tick();
    check_eq("c17_count", count, 17);
    check_eq("c17_sample", sample_out, 8'h02);
    drive(1'b1, 1'b1, 32'hA3A2A1A0, 1'b1, 1'b0);
    check_eq("coinc_count", count, 20);
    check_eq("coinc_sample", sample_out, 8'h03);
    check_eq("coinc_req", sound_req, 0);
    for (int j = 0; j < 4; j++) begin
      tick();
      check_eq($sformatf("hys_a_count%0d", j), count, 19 - j);
      check_eq($sformatf("hys_a_req%0d", j), sound_req, (j == 3) ? 1 : 0);
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      check_eq($sformatf("hys_b_req%0d", j), sound_req, 0);
    end
    check_eq("hys_b_count", count, 12);
    fill_words(2);
    check_eq("refill_count", count, 20);
    check_eq("refill_req", sound_req, 0);
    for (int j = 0; j < 4; j++) begin
      tick();
      check_eq($sformatf("hys_c_req%0d", j), sound_req, (j == 3) ? 1 : 0);
    end
    check_eq("hys_c_sample", sample_out, 8'h0F);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("wait_req", sound_req, 0);

    // Clear wins over coincident write and pop while in WAIT.
    drive(1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
    check_eq("clrprio_count", count, 0);
    check_eq("clrprio_sample", sample_out, 0);
    check_eq("clrprio_ovf", overflow, 0);
    check_eq("clrprio_udf", underflow, 0);
    check_eq("clrprio_req", sound_req, 0);
    tick();
    check_eq("clrprio_tick_udf", underflow, 1);
    check_eq("clrprio_tick_count", count, 0);
    // FSM left WAIT: a pop to 15 from IDLE must request.
    fill_words(4);
    check_eq("idle_fill_req", sound_req, 0);
    tick();
    check_eq("idle_pop_req", sound_req, 1);
    check_eq("idle_pop_count", count, 15);
    tick();
    check_eq("idle_pop2_sample", sample_out, 8'h01);

    // Asynchronous reset mid-stream.
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_sample", sample_out, 0);
    check_eq("arst_count", count, 0);
    check_eq("arst_req", sound_req, 0);
    check_eq("arst_ovf", overflow, 0);
    check_eq("arst_udf", underflow, 0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("arst_rel_count", count, 0);
    check_eq("arst_rel_udf", underflow, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
